// File: rtl/msg_route_pkg.sv
// msg_route_pkg: shared constants and helpers for the message route queue.
// Holds the idle message, the default valid-bit index, the "no destination"
// code and a helper that pulls the 2-bit destination field out of a message.
package msg_route_pkg;

    // Widest message any instance may use; helpers take messages zero-extended to this.
    localparam int MSG_MAX_WID = 256;

    // Default message width and its valid-flag position.
    localparam int DEF_WID   = 132;
    localparam int VALID_BIT = DEF_WID - 1;

    // Message presented to the splitter when nothing is queued.
    localparam logic [MSG_MAX_WID-1:0] IDLE_MSG = '0;

    // Destination code meaning "route nowhere"; such messages are dropped.
    localparam logic [1:0] DST_NONE = 2'd0;

    // Extracts the 2-bit destination field whose LSB sits at bit position lo.
    function automatic logic [1:0] dst_of(input logic [MSG_MAX_WID-1:0] msg,
                                          input logic [7:0]             lo);
        return msg[lo +: 2];
    endfunction

endpackage

// File: rtl/msg_route_queue_if.sv
// msg_route_queue_if: producer and splitter handshake signals of the route queue.
// The slave modport is the queue's view; the master modport is the
// environment's view (producer driving msgin, splitter driving msgoutack).
interface msg_route_queue_if #(
    parameter int WID = 132
);
    logic [WID-1:0] msgin;
    logic           msginack;
    logic [WID-1:0] msgout;
    logic [1:0]     sel;
    logic           msgoutack;

    modport slave (
        input  msgin,
        output msginack,
        output msgout,
        output sel,
        input  msgoutack
    );

    modport master (
        output msgin,
        input  msginack,
        input  msgout,
        input  sel,
        output msgoutack
    );

endinterface

// File: rtl/msg_fifo_core.sv
// msg_fifo_core: plain message FIFO storage with read/write pointers and an
// occupancy count. Full and empty are derived from the count so the pointers
// never need an extra wrap bit. Push while full and pop while empty are ignored.
module msg_fifo_core #(
    parameter int WID   = 132,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WID-1:0]           push_data,
    input  logic                     pop,
    output logic [WID-1:0]           head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WID-1:0] mem [DEPTH];
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rptr];

    // Storage is write-only on push; stale contents are never shown because the
    // wrapper masks the head while empty, so the array needs no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy,
    // staying unchanged when a push and a pop land on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/msg_route_queue.sv
// msg_route_queue: buffers producer messages and feeds the head, plus its
// destination select, to the 3-way splitter. Messages with destination 0 are
// acknowledged but discarded. Build option MSG_ROUTE_STATS_EN adds a saturating
// drop counter; without it drop_count is tied to zero and no counter flops exist.
module msg_route_queue
    import msg_route_pkg::*;
#(
    parameter int WID   = 132,
    parameter int DEPTH = 4,
    parameter int DSTLO = 124,
    parameter int CNTW  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    msg_route_queue_if.slave       mif,
    output logic [$clog2(DEPTH):0] count,
    output logic [CNTW-1:0]        drop_count
);

    localparam int PADW = MSG_MAX_WID - WID;

    logic           full;
    logic           empty;
    logic [WID-1:0] head;
    logic           accept;
    logic           drop;
    logic           push;
    logic           pop;
    logic [1:0]     in_dst;
    logic [1:0]     head_dst;

    assign in_dst   = dst_of({{PADW{1'b0}}, mif.msgin}, 8'(DSTLO));
    assign head_dst = dst_of({{PADW{1'b0}}, head}, 8'(DSTLO));

    // Accept depends only on the producer's valid flag and the stored count, so
    // there is no path from the splitter ack; a pop cannot make room the same
    // cycle. Held low during reset so nothing is acknowledged while discarding.
    assign accept       = rst_n & mif.msgin[WID-1] & ~full;
    assign mif.msginack = accept;
    assign drop         = accept & (in_dst == DST_NONE);
    assign push         = accept & ~drop;
    assign pop          = ~empty & mif.msgoutack;

    // Head is only shown once it is stored, giving one cycle of latency and idle
    // zeros when empty, which in turn makes the splitter return no ack.
    assign mif.msgout = empty ? IDLE_MSG[WID-1:0] : head;
    assign mif.sel    = empty ? DST_NONE : head_dst;

    msg_fifo_core #(
        .WID   (WID),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (mif.msgin),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

`ifdef MSG_ROUTE_STATS_EN
    logic [CNTW-1:0] drop_cnt_q;

    // Counts discarded destination-0 messages, sticking at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    assign drop_count = drop_cnt_q;
`else
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_msg_route_queue.sv
// tb_msg_route_queue: directed self-checking bench for msg_route_queue.
// A second instance with a 2-bit drop counter shares the same stimulus so the
// counter's saturation can be reached in a handful of drops.
module tb_msg_route_queue;
    import msg_route_pkg::*;

`ifdef MSG_ROUTE_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [2:0] count;
    logic [15:0] drop_count;
    logic [2:0] count_s;
    logic [1:0] drop_count_s;

    int checks;
    int errors;

    msg_route_queue_if #(.WID(132)) bus_m ();
    msg_route_queue_if #(.WID(132)) bus_s ();

    assign bus_s.msgin     = bus_m.msgin;
    assign bus_s.msgoutack = bus_m.msgoutack;

    msg_route_queue #(
        .WID(132), .DEPTH(4), .DSTLO(124), .CNTW(16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mif        (bus_m.slave),
        .count      (count),
        .drop_count (drop_count)
    );

    msg_route_queue #(
        .WID(132), .DEPTH(4), .DSTLO(124), .CNTW(2)
    ) dut_small (
        .clk        (clk),
        .rst_n      (rst_n),
        .mif        (bus_s.slave),
        .count      (count_s),
        .drop_count (drop_count_s)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [131:0] mk(input logic [1:0] dst, input logic [7:0] pl);
        logic [131:0] m;
        m          = '0;
        m[131]     = 1'b1;
        m[125:124] = dst;
        m[7:0]     = pl;
        return m;
    endfunction

    task automatic checkOutput(input string tag, input logic [131:0] actual,
                               input logic [131:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Drives one cycle of inputs just after the falling edge; checks then follow
    // well before the next rising edge.
    task automatic applyStimulus(input logic [131:0] m, input logic ack);
        @(negedge clk);
        bus_m.msgin     = m;
        bus_m.msgoutack = ack;
        #1;
    endtask

    logic [1:0] fd [5];

    initial begin
        checks = 0;
        errors = 0;
        fd = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2};
        rst_n = 1'b0;
        bus_m.msgin = '0;
        bus_m.msgoutack = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_count", count, 0);
        checkOutput("rst_msgout", bus_m.msgout, 0);
        checkOutput("rst_drop", drop_count, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            applyStimulus('0, 1'b0);
            checkOutput("idle_ack", bus_m.msginack, 0);
            checkOutput("idle_msgout", bus_m.msgout, 0);
            checkOutput("idle_sel", bus_m.sel, 0);
            checkOutput("idle_count", count, 0);
        end

        // Single route, one cycle of latency
        applyStimulus(mk(2'd2, 8'hA5), 1'b0);
        checkOutput("route_ack", bus_m.msginack, 1);
        checkOutput("route_sel_pre", bus_m.sel, 0);
        checkOutput("route_msgout_pre", bus_m.msgout, 0);
        applyStimulus('0, 1'b0);
        checkOutput("route_msgout", bus_m.msgout, mk(2'd2, 8'hA5));
        checkOutput("route_sel", bus_m.sel, 2);
        checkOutput("route_count", count, 1);
        applyStimulus('0, 1'b1);
        checkOutput("route_hold", bus_m.msgout, mk(2'd2, 8'hA5));
        applyStimulus('0, 1'b0);
        checkOutput("route_count_post", count, 0);
        checkOutput("route_sel_post", bus_m.sel, 0);
        checkOutput("route_msgout_post", bus_m.msgout, 0);

        // Fill to DEPTH, then backpressure
        for (int i = 0; i < 4; i++) begin
            applyStimulus(mk(fd[i], 8'(16 + i)), 1'b0);
            checkOutput("fill_ack", bus_m.msginack, 1);
        end
        applyStimulus(mk(fd[4], 8'h14), 1'b0);
        checkOutput("full_ack", bus_m.msginack, 0);
        checkOutput("full_count", count, 4);
        checkOutput("full_head", bus_m.msgout, mk(2'd1, 8'h10));
        applyStimulus(mk(fd[4], 8'h14), 1'b1);
        checkOutput("full_nobypass", bus_m.msginack, 0);
        applyStimulus(mk(fd[4], 8'h14), 1'b0);
        checkOutput("retry_ack", bus_m.msginack, 1);
        checkOutput("retry_count", count, 3);
        checkOutput("retry_head", bus_m.msgout, mk(2'd2, 8'h11));
        for (int i = 1; i < 5; i++) begin
            applyStimulus('0, 1'b1);
            checkOutput("drain_msgout", bus_m.msgout, mk(fd[i], 8'(16 + i)));
            checkOutput("drain_sel", bus_m.sel, fd[i]);
        end
        applyStimulus('0, 1'b0);
        checkOutput("drain_count", count, 0);

        // Simultaneous push and pop at count 2
        applyStimulus(mk(2'd1, 8'h20), 1'b0);
        applyStimulus(mk(2'd3, 8'h21), 1'b0);
        applyStimulus(mk(2'd2, 8'h22), 1'b1);
        checkOutput("sim_ack", bus_m.msginack, 1);
        checkOutput("sim_count_pre", count, 2);
        checkOutput("sim_head_pre", bus_m.msgout, mk(2'd1, 8'h20));
        applyStimulus('0, 1'b0);
        checkOutput("sim_count", count, 2);
        checkOutput("sim_head", bus_m.msgout, mk(2'd3, 8'h21));
        applyStimulus('0, 1'b1);
        checkOutput("sim_out1", bus_m.msgout, mk(2'd3, 8'h21));
        applyStimulus('0, 1'b1);
        checkOutput("sim_out2", bus_m.msgout, mk(2'd2, 8'h22));
        applyStimulus('0, 1'b0);
        checkOutput("sim_count_post", count, 0);

        // Drop destination-0 messages
        for (int i = 0; i < 3; i++) begin
            applyStimulus(mk(2'd0, 8'(64 + i)), 1'b0);
            checkOutput("drop_ack", bus_m.msginack, 1);
        end
        applyStimulus('0, 1'b0);
        checkOutput("drop_count_q", count, 0);
        checkOutput("drop_msgout", bus_m.msgout, 0);
        checkOutput("drop_sel", bus_m.sel, 0);
        checkOutput("drop_cnt3", drop_count, STATS_ON ? 3 : 0);
        checkOutput("drop_small3", drop_count_s, STATS_ON ? 3 : 0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(mk(2'd0, 8'(80 + i)), 1'b0);
        end
        applyStimulus('0, 1'b0);
        checkOutput("drop_cnt5", drop_count, STATS_ON ? 5 : 0);
        checkOutput("drop_small_sat", drop_count_s, STATS_ON ? 3 : 0);

        // Async reset mid-stream
        applyStimulus(mk(2'd1, 8'h50), 1'b0);
        applyStimulus(mk(2'd2, 8'h51), 1'b0);
        applyStimulus(mk(2'd3, 8'h52), 1'b0);
        applyStimulus('0, 1'b0);
        checkOutput("areset_count_pre", count, 3);
        bus_m.msgin = mk(2'd1, 8'h53);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("areset_msgout", bus_m.msgout, 0);
        checkOutput("areset_sel", bus_m.sel, 0);
        checkOutput("areset_count", count, 0);
        checkOutput("areset_ack", bus_m.msginack, 0);
        checkOutput("areset_drop", drop_count, 0);
        checkOutput("areset_small_drop", drop_count_s, 0);
        @(negedge clk);
        bus_m.msgin = '0;
        rst_n = 1'b1;
        applyStimulus(mk(2'd3, 8'h60), 1'b0);
        checkOutput("post_ack", bus_m.msginack, 1);
        applyStimulus('0, 1'b0);
        checkOutput("post_msgout", bus_m.msgout, mk(2'd3, 8'h60));
        checkOutput("post_sel", bus_m.sel, 3);
        checkOutput("post_count", count, 1);
        applyStimulus('0, 1'b1);
        applyStimulus('0, 1'b0);
        checkOutput("post_count_end", count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/msg_route_queue.md
Name: msg_route_queue

Overview:
- Upstream feeder for the 3-way message splitter.
- Accepts messages from a producer over a valid-in-message/ack handshake and buffers them in a small FIFO.
- Presents the head message together with a 2-bit destination select taken from the head's header. The splitter uses that select to steer the message to port a, b or c.
- Pops the head when the selected destination acks. Drops messages whose destination field is 0.

Parameters:
- WID, 132, message width in bits; bit WID-1 is the valid flag.
- DEPTH, 4, FIFO entries; power of two, min 2.
- DSTLO, 124, LSB of the 2-bit destination field msg[DSTLO+1:DSTLO].
- CNTW, 16, width of the drop counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- msgin  input  WID  producer message; valid when msgin[WID-1]=1.
- msginack  output  1  accept strobe to producer.
- msgout  output  WID  head message to splitter.
- sel  output  2  destination select to splitter.
- msgoutack  input  1  ack from splitter (its muxed acka/ackb/ackc).
- count  output  $clog2(DEPTH)+1  current occupancy.
- drop_count  output  CNTW  dropped-message count.

Behaviour:
- Single clock clk; reset asynchronous, active-low rst_n.
- Reset state:
  - FIFO empty; read/write pointers 0; count=0; drop_count=0.
  - msgout=all-zero idle message; sel=0; msginack=0.
- Enqueue (combinational accept):
  - msginack = msgin[WID-1] & !full, where full = (count==DEPTH).
  - An accept occurs on any clk edge with msginack=1.
  - If the accepted message has dst field = 0: it is acked but not written, and drop_count increments, saturating at all-ones.
  - Otherwise: written at wptr; wptr advances with wrap at DEPTH.
- Dequeue:
  - When not empty: msgout = mem[rptr] and sel = mem[rptr][DSTLO+1:DSTLO], which is always nonzero.
  - When empty: msgout = 0 and sel = 0. The splitter then returns ack 0.
  - A pop occurs on a clk edge with !empty & msgoutack; rptr advances with wrap.
  - msgoutack while empty is ignored.
- Simultaneous push and pop in one cycle:
  - count is unchanged; both pointers advance.
  - When full, push is blocked by msginack=0 even if a pop occurs that cycle (no full-bypass).
  - Empty FIFO: no write-through. A message accepted at edge N appears on msgout after edge N, i.e. one cycle of latency.
- No combinational path from msgoutack to msginack.
- count = entries held, 0..DEPTH. Pointers are $clog2(DEPTH) bits; full/empty are derived from count.
- The head is stable while not popped; msgout/sel change only after a pop or the first push into an empty FIFO.
- Reset mid-operation discards all entries immediately (async); outputs return to reset values.

Optional Feature:
- Macro: MSG_ROUTE_STATS_EN.
- Defined: the drop counter is implemented as above.
- Undefined: no counter flops. drop_count is tied to 0; drop-on-dst0 still happens. The port list is identical in both builds.

Decomposition:
- Shared package msg_route_pkg:
  - localparams for the idle message (all zero), the valid-bit index and the DST_NONE=2'd0 code.
  - A function extracting the dst field.
- One natural sub-module: msg_fifo_core.
  - Parameterized WID/DEPTH storage plus pointers and count; push/pop in, full/empty/head out.
  - msg_route_queue wraps it with accept, drop and select logic.

Test Plan:
- Reset then idle: rst_n low, then high with msgin=0 → msginack=0, msgout=0, sel=0, count=0 for 10 cycles.
- Single route:
  - Push valid msg with dst=2, payload 0xA5.
  - Expect msginack=1 in that cycle, then sel=2 and msgout=msg one cycle later.
  - Ack in cycle 3 → count=0, sel=0 next cycle.
- Fill/backpressure:
  - DEPTH=4, push 5 msgs (dst 1,2,3,1,2) with no ack.
  - Expect msginack=0 on the 5th push while count=4.
  - Pop one → 5th accepted next edge; order out 1,2,3,1,2.
- Simultaneous push/pop at count=2 → count stays 2, FIFO order preserved.
- Drop:
  - Push 3 msgs with dst=0 → each acked, count stays 0, drop_count=3 (0 without MSG_ROUTE_STATS_EN).
  - Also force drop_count near saturation → it holds at 0xFFFF.
- Async reset with count=3 mid-stream → outputs go to reset values immediately without a clock edge; post-reset pushes are routed correctly.
